// File: rtl/ps2_uart_bridge_if.sv
// ps2_uart_bridge_if: signal bundle between the PS/2-to-UART bridge and
// its surroundings.
//   slave  : the bridge itself (takes the PS/2 lines and controls,
//            drives code / status / serial outputs)
//   master : whatever drives the bridge (keyboard side plus host controls)
// Signals:
//   ps2_clk_i, ps2_data_i : raw asynchronous PS/2 lines
//   tx_en_i               : level, allows the UART engine to pop the FIFO
//   flush_i               : one-cycle pulse, empties FIFO and sticky flags
//   ps2_code_o            : last correctly framed byte
//   code_valid_o          : one-cycle pulse when ps2_code_o updates
//   fifo_count_o          : FIFO occupancy, $clog2(FIFO_DEPTH)+1 bits
//   overflow_o            : sticky, byte dropped on a full FIFO
//   frame_err_o           : sticky, parity / stop / timeout error
//   tx_busy_o             : UART frame in progress
//   uart_tx_o             : serial line, idles high
interface ps2_uart_bridge_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ps2_clk_i;
    logic          ps2_data_i;
    logic          tx_en_i;
    logic          flush_i;
    logic [7:0]    ps2_code_o;
    logic          code_valid_o;
    logic [CW-1:0] fifo_count_o;
    logic          overflow_o;
    logic          frame_err_o;
    logic          tx_busy_o;
    logic          uart_tx_o;

    modport slave (
        input  ps2_clk_i, ps2_data_i, tx_en_i, flush_i,
        output ps2_code_o, code_valid_o, fifo_count_o,
               overflow_o, frame_err_o, tx_busy_o, uart_tx_o
    );

    modport master (
        output ps2_clk_i, ps2_data_i, tx_en_i, flush_i,
        input  ps2_code_o, code_valid_o, fifo_count_o,
               overflow_o, frame_err_o, tx_busy_o, uart_tx_o
    );
endinterface

// File: rtl/ps2_uart_bridge.sv
// ps2_uart_bridge: receives PS/2 scan-code frames, buffers good bytes in a
// FIFO and streams them out as 8N1/8N2 UART frames.
// Ports:
//   clk_i   : system clock, everything on its rising edge
//   reset_i : synchronous, active-high reset
//   bus     : ps2_uart_bridge_if.slave (PS/2 lines, tx_en/flush controls,
//             code / FIFO / sticky-flag status and the UART line)
// Parameters: CLK_HZ, BAUD (bit period DIV = CLK_HZ/BAUD >= 4),
//   FIFO_DEPTH (power of 2, >= 2), STOP_BITS (1 or 2), PS2_TIMEOUT_CYC.
// Optional feature: define BRIDGE_BREAK_FILTER_EN to keep 8'hF0 and the
//   byte following it out of the FIFO (break codes never reach the UART).
module ps2_uart_bridge #(
    parameter int CLK_HZ          = 10_000_000,
    parameter int BAUD            = 115200,
    parameter int FIFO_DEPTH      = 16,
    parameter int STOP_BITS       = 1,
    parameter int PS2_TIMEOUT_CYC = 10_000
) (
    input logic              clk_i,
    input logic              reset_i,
    ps2_uart_bridge_if.slave bus
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BCW = $clog2(DIV);
    localparam int TCW = $clog2(PS2_TIMEOUT_CYC + 1);

    // ------------------------------------------------------------------
    // Input synchronizers. ps2_clk_sr[1] is the synchronized clock,
    // ps2_clk_sr[2] its previous value for falling-edge detection.
    // ------------------------------------------------------------------
    logic [2:0] ps2_clk_sr;
    logic [1:0] ps2_dat_sr;
    logic       ps2_fall;
    logic       ps2_bit;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ps2_clk_sr <= 3'b111;
            ps2_dat_sr <= 2'b11;
        end else begin
            ps2_clk_sr <= {ps2_clk_sr[1:0], bus.ps2_clk_i};
            ps2_dat_sr <= {ps2_dat_sr[0], bus.ps2_data_i};
        end
    end

    assign ps2_fall = ps2_clk_sr[2] & ~ps2_clk_sr[1];
    assign ps2_bit  = ps2_dat_sr[1];

    // ------------------------------------------------------------------
    // PS/2 receive FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t      rx_state, rx_state_nx;
    logic [2:0]     rx_bit_cnt;
    logic [7:0]     rx_shift;
    logic [TCW-1:0] rx_idle_cnt;
    logic           rx_timeout;
    logic           rx_good;
    logic           rx_err;

    // Fires on the PS2_TIMEOUT_CYC-th consecutive cycle without an edge.
    assign rx_timeout = (rx_state != RX_IDLE) && !ps2_fall &&
                        (rx_idle_cnt == TCW'(PS2_TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) rx_state <= RX_IDLE;
        else         rx_state <= rx_state_nx;
    end

    always_comb begin
        rx_state_nx = rx_state;
        rx_good     = 1'b0;
        rx_err      = 1'b0;
        if (rx_timeout) begin
            rx_state_nx = RX_IDLE;
            rx_err      = 1'b1;
        end else if (ps2_fall) begin
            case (rx_state)
                RX_IDLE:   if (!ps2_bit) rx_state_nx = RX_DATA;
                RX_DATA:   if (rx_bit_cnt == 3'd7) rx_state_nx = RX_PARITY;
                RX_PARITY: begin
                    // odd parity: data plus parity bit must hold an odd count of ones
                    if (^{rx_shift, ps2_bit}) begin
                        rx_state_nx = RX_STOP;
                    end else begin
                        rx_state_nx = RX_IDLE;
                        rx_err      = 1'b1;
                    end
                end
                RX_STOP: begin
                    rx_state_nx = RX_IDLE;
                    if (ps2_bit) rx_good = 1'b1;
                    else         rx_err  = 1'b1;
                end
                default: rx_state_nx = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_bit_cnt  <= '0;
            rx_shift    <= '0;
            rx_idle_cnt <= '0;
        end else begin
            if (rx_state == RX_IDLE || ps2_fall) rx_idle_cnt <= '0;
            else                                 rx_idle_cnt <= rx_idle_cnt + TCW'(1);

            if (rx_state == RX_IDLE) begin
                rx_bit_cnt <= '0;
            end else if (rx_state == RX_DATA && ps2_fall) begin
                rx_shift   <= {ps2_bit, rx_shift[7:1]};   // LSB arrives first
                rx_bit_cnt <= rx_bit_cnt + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Code output and push request (one cycle after the stop-bit edge)
    // ------------------------------------------------------------------
    logic [7:0] code_q;
    logic       code_vld_q;
    logic       push_req;
    logic       keep_byte;

`ifdef BRIDGE_BREAK_FILTER_EN
    // brk_pend: an F0 was seen, so the next good byte is its break payload.
    logic brk_pend;

    assign keep_byte = !brk_pend && (rx_shift != 8'hF0);

    always_ff @(posedge clk_i) begin
        if (reset_i || bus.flush_i) brk_pend <= 1'b0;
        else if (rx_good)           brk_pend <= !brk_pend && (rx_shift == 8'hF0);
    end
`else
    assign keep_byte = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            code_q     <= '0;
            code_vld_q <= 1'b0;
            push_req   <= 1'b0;
        end else begin
            code_vld_q <= rx_good;
            push_req   <= rx_good && keep_byte;
            if (rx_good) code_q <= rx_shift;
        end
    end

    // ------------------------------------------------------------------
    // Scan-code FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full;
    logic          tx_pop;
    logic          push_ok;
    logic          overflow_q;
    logic          frame_err_q;

    assign fifo_full = (count == CW'(FIFO_DEPTH));
    // A pop can only happen with count > 0, so push+pop on empty is push only.
    assign push_ok   = push_req && (!fifo_full || tx_pop);

    always_ff @(posedge clk_i) begin
        if (push_ok && !bus.flush_i) fifo_mem[wr_ptr] <= code_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (tx_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, tx_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || bus.flush_i) begin
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (push_req && !push_ok) overflow_q  <= 1'b1;
            if (rx_err)               frame_err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // UART transmit FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t      tx_state, tx_state_nx;
    logic [BCW-1:0] baud_cnt;
    logic [2:0]     tx_bit_cnt;
    logic           tx_stop_cnt;
    logic [7:0]     tx_shift;
    logic           baud_tick;
    logic           last_stop;
    logic           tx_line;
    logic           tx_busy_q;

    assign tx_pop    = (tx_state == TX_IDLE) && bus.tx_en_i && (count != '0);
    assign baud_tick = (baud_cnt == BCW'(DIV - 1));
    assign last_stop = (tx_stop_cnt == 1'(STOP_BITS - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i) tx_state <= TX_IDLE;
        else         tx_state <= tx_state_nx;
    end

    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_pop) tx_state_nx = TX_START;
            TX_START: if (baud_tick) tx_state_nx = TX_DATA;
            TX_DATA:  if (baud_tick && tx_bit_cnt == 3'd7) tx_state_nx = TX_STOP;
            TX_STOP:  if (baud_tick && last_stop) tx_state_nx = TX_IDLE;
            default:  tx_state_nx = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            baud_cnt    <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
            tx_shift    <= '0;
        end else if (tx_state == TX_IDLE) begin
            baud_cnt    <= '0;
            tx_bit_cnt  <= '0;
            tx_stop_cnt <= 1'b0;
            if (tx_pop) tx_shift <= fifo_mem[rd_ptr];
        end else if (baud_tick) begin
            baud_cnt <= '0;
            if (tx_state == TX_DATA) begin
                tx_shift   <= {1'b1, tx_shift[7:1]};
                tx_bit_cnt <= tx_bit_cnt + 3'd1;
            end
            if (tx_state == TX_STOP) tx_stop_cnt <= 1'b1;
        end else begin
            baud_cnt <= baud_cnt + BCW'(1);
        end
    end

    // Line and busy are registered from the next state so the pin never
    // glitches on state transitions.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_line   <= 1'b1;
            tx_busy_q <= 1'b0;
        end else begin
            tx_busy_q <= (tx_state_nx != TX_IDLE);
            case (tx_state_nx)
                TX_START: tx_line <= 1'b0;
                TX_DATA:  tx_line <= (tx_state == TX_DATA && baud_tick) ? tx_shift[1]
                                                                        : tx_shift[0];
                default:  tx_line <= 1'b1;
            endcase
        end
    end

    assign bus.ps2_code_o   = code_q;
    assign bus.code_valid_o = code_vld_q;
    assign bus.fifo_count_o = count;
    assign bus.overflow_o   = overflow_q;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.tx_busy_o    = tx_busy_q;
    assign bus.uart_tx_o    = tx_line;
endmodule

// File: tb/tb_ps2_uart_bridge.sv
module tb_ps2_uart_bridge;
    localparam int CLK_HZ     = 1_000_000;
    localparam int BAUD       = 100_000;
    localparam int FIFO_DEPTH = 4;
    localparam int STOP_BITS  = 1;
    localparam int TO_CYC     = 200;
    localparam int DIV        = 10;                    // 1 MHz / 100 kHz
    localparam int FRAME_CYC  = DIV * (9 + STOP_BITS); // start + 8 data + stops
    localparam int HALF       = 20;                    // PS/2 half period in clk cycles

    logic clk = 1'b0;
    logic reset = 1'b1;

    ps2_uart_bridge_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    ps2_uart_bridge #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH),
        .STOP_BITS(STOP_BITS), .PS2_TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_i(clk), .reset_i(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    int n_codes = 0;

    // reference model
    logic [7:0] m_fifo[$];     // bytes still owed on the UART, in order
    logic [7:0] exp_code[$];   // bytes owed on code_valid_o
    bit m_ovf = 0, m_ferr = 0, m_brk = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_msg(input string msg);
        n_chk++;
        $display("FAIL %s", msg);
    endtask

    // err: 0 good, 1 bad parity, 2 bad stop bit
    task automatic model_frame(input logic [7:0] b, input int err);
        bit drop;
        drop = 0;
        if (err != 0) begin
            m_ferr = 1;
        end else begin
            exp_code.push_back(b);
`ifdef BRIDGE_BREAK_FILTER_EN
            if (m_brk) begin drop = 1; m_brk = 0; end
            else if (b == 8'hF0) begin drop = 1; m_brk = 1; end
`endif
            if (!drop) begin
                if (m_fifo.size() >= FIFO_DEPTH) m_ovf = 1;
                else m_fifo.push_back(b);
            end
        end
    endtask

    // stall_after >= 0: clock stops after that many data bits
    task automatic ps2_send(input logic [7:0] b, input int err, input int stall_after);
        logic [10:0] bits;
        bits = {(err == 2) ? 1'b0 : 1'b1, (err == 1) ? ^b : ~^b, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (stall_after >= 0 && i == stall_after + 1) begin
                bus.ps2_data_i = 1'b1;
                repeat (TO_CYC + HALF) @(negedge clk);
                m_ferr = 1;
                return;
            end
            bus.ps2_data_i = bits[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk_i = 1'b0;
            if (i == 10) model_frame(b, err);
            repeat (HALF) @(negedge clk);
            bus.ps2_clk_i = 1'b1;
        end
        bus.ps2_data_i = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic pulse_flush();
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        m_ferr = 0; m_ovf = 0; m_brk = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((m_fifo.size() != 0 || bus.tx_busy_o || bus.fifo_count_o != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) fail_msg("drain: UART never emptied within 5000 cycles");
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, output int cyc);
        cyc = 0;
        while (bus.tx_busy_o !== lvl && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= budget)
            $display("FAIL wait_busy: tx_busy_o never reached %0d within %0d cycles", lvl, budget);
        if (cyc >= budget) n_chk++;
    endtask

    // code_valid_o monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.code_valid_o === 1'b1) begin
                n_codes++;
                if (exp_code.size() == 0)
                    fail_msg($sformatf("code_valid: unexpected pulse with code 0x%0h", bus.ps2_code_o));
                else
                    check("ps2_code", bus.ps2_code_o, exp_code.pop_front());
            end
        end
    end

    // UART line monitor: samples each bit at its middle
    logic [7:0] mon_byte;
    bit mon_ab, mon_start, mon_stop;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && bus.uart_tx_o === 1'b0) begin
                mon_ab = 0;
                repeat (DIV / 2) begin @(negedge clk); mon_ab |= reset; end
                mon_start = bus.uart_tx_o;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) begin @(negedge clk); mon_ab |= reset; end
                    mon_byte[i] = bus.uart_tx_o;
                end
                repeat (DIV) begin @(negedge clk); mon_ab |= reset; end
                mon_stop = bus.uart_tx_o;
                if (!mon_ab) begin
                    check("uart_start", mon_start, 0);
                    check("uart_stop", mon_stop, 1);
                    if (m_fifo.size() == 0)
                        fail_msg($sformatf("uart: unexpected frame carrying 0x%0h", mon_byte));
                    else
                        check("uart_byte", mon_byte, m_fifo.pop_front());
                end
            end
        end
    end

    // tx_busy_o must stay high for exactly one frame time
    int busy_run = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (reset) busy_run = 0;
            else if (bus.tx_busy_o === 1'b1) busy_run++;
            else if (busy_run != 0) begin
                check("tx_busy_len", busy_run, FRAME_CYC);
                busy_run = 0;
            end
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, n0, err, r;
        logic [7:0] b;
        bus.ps2_clk_i = 1'b1; bus.ps2_data_i = 1'b1;
        bus.tx_en_i = 1'b0; bus.flush_i = 1'b0;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_code", bus.ps2_code_o, 0);
        check("rst_valid", bus.code_valid_o, 0);
        check("rst_count", bus.fifo_count_o, 0);
        check("rst_ovf", bus.overflow_o, 0);
        check("rst_ferr", bus.frame_err_o, 0);
        check("rst_busy", bus.tx_busy_o, 0);
        check("rst_tx", bus.uart_tx_o, 1);
        reset = 1'b0;
        @(negedge clk);

        // single good frame
        bus.tx_en_i = 1'b1;
        n0 = n_codes;
        ps2_send(8'h1C, 0, -1);
        drain();
        check("one_code_pulse", n_codes - n0, 1);

        // bad parity
        ps2_send(8'h1C, 1, -1);
        repeat (5) @(negedge clk);
        check("perr_ferr", bus.frame_err_o, m_ferr);
        check("perr_count", bus.fifo_count_o, 0);
        pulse_flush();
        check("flush_ferr", bus.frame_err_o, m_ferr);

        // timeout after 4 data bits, then a good frame
        ps2_send(8'h1C, 0, 4);
        check("to_ferr", bus.frame_err_o, m_ferr);
        check("to_count", bus.fifo_count_o, 0);
        ps2_send(8'h32, 0, -1);
        drain();
        pulse_flush();

        // overflow with TX disabled, then back-to-back drain
        bus.tx_en_i = 1'b0;
        for (int i = 0; i < 6; i++) ps2_send(8'h15 + 8'(i), 0, -1);
        repeat (5) @(negedge clk);
        check("ovf_count", bus.fifo_count_o, m_fifo.size());
        check("ovf_flag", bus.overflow_o, m_ovf);
        bus.tx_en_i = 1'b1;
        wait_busy(1'b1, 50, c);
        for (int g = 0; g < 3; g++) begin
            wait_busy(1'b0, 200, c);
            wait_busy(1'b1, 50, c);
            check("b2b_gap", c, 1);
        end
        drain();
        check("ovf_sticky", bus.overflow_o, m_ovf);
        pulse_flush();
        check("flush_ovf", bus.overflow_o, m_ovf);

        // break-code sequence
        n0 = n_codes;
        ps2_send(8'h1C, 0, -1);
        ps2_send(8'hF0, 0, -1);
        ps2_send(8'h1C, 0, -1);
        ps2_send(8'hE0, 0, -1);
        ps2_send(8'h75, 0, -1);
        drain();
        check("brk_pulses", n_codes - n0, 5);

        // randomized frames
        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            err = (r < 7) ? 0 : (r < 9) ? 1 : 2;
            ps2_send(b, err, -1);
            repeat ($urandom_range(8, 60)) @(negedge clk);
            check("rand_ferr", bus.frame_err_o, m_ferr);
            check("rand_ovf", bus.overflow_o, m_ovf);
            if ($urandom_range(0, 3) == 0) begin
                pulse_flush();
                check("rand_flush_ferr", bus.frame_err_o, m_ferr);
            end
        end
        drain();

        // reset in the middle of data bit 3
        bus.tx_en_i = 1'b0;
        ps2_send(8'h5A, 0, -1);
        ps2_send(8'hA5, 0, -1);
        repeat (5) @(negedge clk);
        check("pre_rst_count", bus.fifo_count_o, m_fifo.size());
        bus.tx_en_i = 1'b1;
        wait_busy(1'b1, 50, c);
        repeat (4 * DIV + DIV / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx", bus.uart_tx_o, 1);
        check("midrst_busy", bus.tx_busy_o, 0);
        check("midrst_count", bus.fifo_count_o, 0);
        @(negedge clk);
        reset = 1'b0;
        m_fifo.delete(); exp_code.delete();
        m_ovf = 0; m_ferr = 0; m_brk = 0;
        repeat (10) @(negedge clk);
        ps2_send(8'h3C, 0, -1);
        drain();

        check("left_codes", exp_code.size(), 0);
        check("left_uart", m_fifo.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_uart_bridge.md
Name: ps2_uart_bridge

Overview:
Parametrised keyboard-to-serial bridge for the peripheral subsystem. It receives PS/2 scan-code frames, buffers valid bytes in a FIFO, and streams them out on an 8N1/8N2 UART TX line. It adds frame error detection, a receive timeout, buffering, flow control and a configurable baud rate.

Parameters:
CLK_HZ, 10_000_000, system clock frequency in Hz.
BAUD, 115200, UART bit rate. Bit period DIV = CLK_HZ/BAUD cycles, integer division truncated, DIV >= 4.
FIFO_DEPTH, 16, scan-code FIFO entries. Power of 2, >= 2.
STOP_BITS, 1, UART stop bits. Legal values are 1 and 2.
PS2_TIMEOUT_CYC, 10_000, idle cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.

Ports:
clk_i  in  1  single system clock; all logic on its rising edge.
reset_i  in  1  synchronous, active-high reset.
ps2_clk_i  in  1  asynchronous PS/2 clock from the keyboard.
ps2_data_i  in  1  asynchronous PS/2 data from the keyboard.
tx_en_i  in  1  level; while high, the TX engine may pop the FIFO.
flush_i  in  1  one-cycle pulse; empties the FIFO and clears the sticky flags.
ps2_code_o  out  8  last correctly framed byte.
code_valid_o  out  1  one-cycle pulse when ps2_code_o updates.
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow_o  out  1  sticky; a byte was dropped because the FIFO was full.
frame_err_o  out  1  sticky; parity error, stop-bit error or timeout.
tx_busy_o  out  1  high while a UART frame is in progress.
uart_tx_o  out  1  serial output; idles high.

Behaviour:
- Reset values: ps2_code_o=0, code_valid_o=0, fifo_count_o=0, overflow_o=0, frame_err_o=0, tx_busy_o=0, uart_tx_o=1. Reset also sets both FSMs to IDLE and empties the FIFO. Reset mid-frame aborts RX and TX immediately.
- Input sync: ps2_clk_i and ps2_data_i each pass through a 2-flop synchronizer. A falling edge is detected on the synchronized clock; data is sampled in that cycle.
- RX FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE to DATA on a falling edge with data=0.
  - DATA captures 8 bits, LSB first.
  - PARITY checks odd parity over the 8 data bits plus the parity bit.
  - STOP requires data=1.
- Timeout: in DATA, PARITY or STOP, if PS2_TIMEOUT_CYC cycles pass with no falling edge, go to IDLE, discard the byte and set frame_err_o.
- Frame errors: a bad parity or stop bit sends the FSM to IDLE, discards the byte and sets frame_err_o.
- Good frame: in the cycle after the stop-bit edge, ps2_code_o is loaded, code_valid_o pulses and a FIFO push is requested.
- FIFO push rules:
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow_o is set.
  - Simultaneous push and pop on an empty FIFO: push only.
  - fifo_count_o updates in the cycle after the push/pop.
- flush_i: the FIFO pointers and count go to 0 and both sticky flags are cleared on the next edge.
  - flush_i wins over a same-cycle push. ps2_code_o and code_valid_o still update.
  - flush_i does not abort a UART frame already in progress.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if tx_en_i=1 and count>0, pop the head into the shift register. On the next cycle uart_tx_o=0 and tx_busy_o=1.
  - START, each DATA bit (LSB first) and each stop bit last exactly DIV cycles, counted by a baud counter that reloads at each bit.
  - After STOP_BITS stop bits at level 1, return to IDLE with tx_busy_o=0.
  - Back-to-back frames: IDLE lasts exactly 1 cycle when the conditions above hold.
- tx_en_i deasserted mid-frame: the current frame completes and no further pop occurs.

Optional Feature:
Macro BRIDGE_BREAK_FILTER_EN.
- Defined: an 8'hF0 byte and the single byte following it are not pushed to the FIFO, so only make codes reach the UART. Both still update ps2_code_o and pulse code_valid_o. 8'hE0 passes normally. The filter's pending flag clears on reset and on flush_i.
- Undefined: every good byte is pushed.

Test Plan:
All scenarios use CLK_HZ=1_000_000, BAUD=100_000 (DIV=10) and FIFO_DEPTH=4.
- PS/2 frame 0x1C with good odd parity, tx_en_i=1 -> one code_valid_o pulse with ps2_code_o=0x1C. uart_tx_o shows start bit, then 0,0,1,1,1,0,0,0, then stop, each 10 cycles. tx_busy_o is high for exactly 100 cycles.
- 0x1C sent with a wrong parity bit -> no code_valid_o, fifo_count_o stays 0, frame_err_o=1. A flush_i pulse then clears it to 0.
- PS/2 clock stalls after 4 data bits for PS2_TIMEOUT_CYC+1 cycles -> frame_err_o=1 and the RX FSM is back in IDLE. The next good frame 0x32 is received correctly.
- tx_en_i=0, six frames 0x15,0x16,0x17,0x18,0x19,0x1A -> fifo_count_o=4 and overflow_o=1. After tx_en_i=1, exactly 0x15..0x18 are transmitted back-to-back with a 1-cycle idle gap.
- Reset asserted at data bit 3 of a UART frame -> uart_tx_o=1, tx_busy_o=0 and fifo_count_o=0 on the next edge.
- With BRIDGE_BREAK_FILTER_EN, sequence 0x1C,0xF0,0x1C,0xE0,0x75 -> FIFO/UART carries 0x1C,0xE0,0x75 and code_valid_o pulses 5 times. Without the macro, all 5 bytes are transmitted.
